dnn_frame_loader: RTL and testbench

- Feeds the DNN inference top and collects its answer.
- Accepts a valid/ready stream of 8-bit pixels and assembles one frame of INPUT_SIZE signed 16-bit elements.
- Holds the frame stable on the DNN input vector, pulses the DNN start, waits for the level-type DNN done, then returns the classified digit through a valid/ready result handshake.

---
 rtl/dnn_frame_loader.sv | 173 +++++++++++++++++
 tb/tb_dnn_frame_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : dnn_frame_loader
//  Purpose  : Assembles a frame of 8-bit pixels from a valid/ready stream into
//             INPUT_SIZE signed 16-bit elements. It holds the frame on the DNN
//             input vector, pulses the DNN start and waits for a rising edge on
//             the level-type DNN done. It then returns the classified digit
//             through a valid/ready result handshake.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             pix_valid/ready/data/last - pixel stream (one pixel per beat)
//             input_vector           - frame buffer, element i at [16*i +: 16]
//             start                  - one-cycle start pulse to the DNN
//             dnn_done, dnn_digit    - DNN completion level and argmax result
//             res_valid/ready/digit  - result handshake
//             frame_err              - one-cycle pulse on short/long frame
//             busy                   - high outside LOAD and DRAIN
//  Revision : 1.0 - initial release
// ============================================================================
module dnn_frame_loader #(
    parameter int INPUT_SIZE = 784,
    parameter int PIX_SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [7:0]                   pix_data,
    input  logic                         pix_last,
    output logic [16*INPUT_SIZE-1:0]     input_vector,
    output logic                         start,
    input  logic                         dnn_done,
    input  logic [3:0]                   dnn_digit,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [3:0]                   res_digit,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_DRAIN  = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_CAP    = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t                      r_state;
    logic [IDX_W-1:0]            r_idx;
    logic [16*INPUT_SIZE-1:0]    r_vec;
    logic                        r_done_prev;
    logic                        r_pix_ready;
    logic                        r_start;
    logic                        r_res_valid;
    logic [3:0]                  r_res_digit;
    logic                        r_frame_err;
    logic                        r_busy;

    logic [15:0]                 w_elem;
    logic                        w_accept;
    logic                        w_at_last;
    logic                        w_write;

    // Zero-extended pixel shifted left; with shifts up to 7 the sign bit stays
    // clear, so every element is a non-negative signed value.
    assign w_elem    = {8'b0, pix_data} << PIX_SHIFT;
    assign w_accept  = pix_valid && r_pix_ready;
    assign w_at_last = (r_idx == c_LAST_IDX);
    // Only in-frame beats are stored: a mid-frame last or a beat past the end
    // of the frame is a framing error and must leave the buffer untouched.
    assign w_write   = (r_state == S_LOAD) && w_accept && (pix_last == w_at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_vec       <= '0;
            r_done_prev <= 1'b1;
            r_pix_ready <= 1'b0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_digit <= 4'd0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_write) begin
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        r_vec[16*i +: 16] <= w_elem;
                    end
                end
            end

            case (r_state)
                S_LOAD: begin
                    r_pix_ready <= 1'b1;
                    if (w_accept) begin
                        if (pix_last) begin
                            r_idx <= '0;
                            if (w_at_last) begin
                                r_state     <= S_START;
                                r_start     <= 1'b1;
                                r_pix_ready <= 1'b0;
                                r_busy      <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else if (w_at_last) begin
                            r_idx       <= '0;
                            r_frame_err <= 1'b1;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept && pix_last) begin
                        r_state <= S_LOAD;
                    end
                end
                S_START: begin
                    // Forcing done_prev high makes a done level left over from
                    // the previous frame invisible until it drops.
                    r_done_prev <= 1'b1;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_done_prev <= dnn_done;
                    if (dnn_done && !r_done_prev) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    // The DNN registers its digit one cycle after done rises.
                    r_res_digit <= dnn_digit;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_pix_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready    = r_pix_ready;
    assign input_vector = r_vec;
    assign start        = r_start;
    assign res_valid    = r_res_valid;
    assign res_digit    = r_res_digit;
    assign frame_err    = r_frame_err;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dnn_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dnn_frame_loader
//  Purpose  : Directed self-checking bench for dnn_frame_loader with
//             INPUT_SIZE=4 and PIX_SHIFT=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_frame_loader;

    localparam int INPUT_SIZE = 4;
    localparam int PIX_SHIFT  = 4;

    logic                       clk;
    logic                       rst_n;
    logic                       pix_valid;
    logic                       pix_ready;
    logic [7:0]                 pix_data;
    logic                       pix_last;
    logic [16*INPUT_SIZE-1:0]   input_vector;
    logic                       start;
    logic                       dnn_done;
    logic [3:0]                 dnn_digit;
    logic                       res_valid;
    logic                       res_ready;
    logic [3:0]                 res_digit;
    logic                       frame_err;
    logic                       busy;

    int n_checks;
    int n_errors;

    dnn_frame_loader #(
        .INPUT_SIZE (INPUT_SIZE),
        .PIX_SHIFT  (PIX_SHIFT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .input_vector (input_vector),
        .start        (start),
        .dnn_done     (dnn_done),
        .dnn_digit    (dnn_digit),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_digit    (res_digit),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Called in the START cycle: runs the DNN handshake and consumes the result.
    task automatic finish_frame(input logic [3:0] digit);
        dnn_done = 1'b0;
        step();
        step();
        dnn_done = 1'b1;
        step();
        dnn_digit = digit;
        step();
        check("ff_res_valid", 64'(res_valid), 64'd1);
        check("ff_res_digit", 64'(res_digit), 64'(digit));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("ff_back_to_load", 64'(pix_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        pix_last  = 1'b0;
        dnn_done  = 1'b1;
        dnn_digit = 4'd3;
        res_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_vector",    input_vector,        64'h0);
        check("rst_start",     64'(start),          64'd0);
        check("rst_res_valid", 64'(res_valid),      64'd0);
        check("rst_res_digit", 64'(res_digit),      64'd0);
        check("rst_frame_err", 64'(frame_err),      64'd0);
        check("rst_pix_ready", 64'(pix_ready),      64'd0);
        check("rst_busy",      64'(busy),           64'd0);
        rst_n = 1'b1;
        step();
        check("rel_pix_ready", 64'(pix_ready), 64'd1);

        // ---------------- nominal frame ----------------
        send_beat(8'h01, 1'b0);
        send_beat(8'h80, 1'b0);
        send_beat(8'hFF, 1'b0);
        check("nom_no_early_start", 64'(start), 64'd0);
        send_beat(8'h00, 1'b1);
        check("nom_start",     64'(start),     64'd1);
        check("nom_pix_ready", 64'(pix_ready), 64'd0);
        check("nom_busy",      64'(busy),      64'd1);
        check("nom_vector",    input_vector,   64'h0000_0FF0_0800_0010);

        // ---------------- done handling (stale high level) ----------------
        step();
        check("nom_start_one_cycle", 64'(start), 64'd0);
        step();
        step();
        check("stale_no_capture", 64'(res_valid), 64'd0);
        dnn_done = 1'b0;
        step();
        step();
        step();
        check("low_no_capture", 64'(res_valid), 64'd0);
        dnn_done = 1'b1;
        step();
        check("rise_plus1_valid", 64'(res_valid), 64'd0);
        dnn_digit = 4'd7;
        step();
        check("rise_plus2_valid", 64'(res_valid), 64'd1);
        check("rise_plus2_digit", 64'(res_digit), 64'd7);

        // ---------------- result backpressure ----------------
        dnn_digit = 4'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid_held", 64'(res_valid), 64'd1);
            check("bp_digit_held", 64'(res_digit), 64'd7);
            check("bp_pix_ready",  64'(pix_ready), 64'd0);
        end
        check("bp_vector_stable", input_vector, 64'h0000_0FF0_0800_0010);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_release_valid", 64'(res_valid), 64'd0);
        check("bp_release_ready", 64'(pix_ready), 64'd1);
        check("bp_release_busy",  64'(busy),      64'd0);

        // ---------------- short frame ----------------
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        check("short_err",       64'(frame_err), 64'd1);
        check("short_no_start",  64'(start),     64'd0);
        check("short_pix_ready", 64'(pix_ready), 64'd1);
        check("short_vector",    input_vector,   64'h0000_0FF0_0800_0110);
        step();
        check("short_err_pulse", 64'(frame_err), 64'd0);
        check("short_no_start2", 64'(start),     64'd0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        send_beat(8'h05, 1'b1);
        check("short_next_start",  64'(start),   64'd1);
        check("short_next_vector", input_vector, 64'h0050_0040_0030_0020);
        finish_frame(4'd2);

        // ---------------- long frame ----------------
        send_beat(8'h06, 1'b0);
        send_beat(8'h07, 1'b0);
        send_beat(8'h08, 1'b0);
        check("long_no_err_yet", 64'(frame_err), 64'd0);
        send_beat(8'h09, 1'b0);
        check("long_err_beat4",  64'(frame_err), 64'd1);
        check("long_drain_rdy",  64'(pix_ready), 64'd1);
        send_beat(8'h0A, 1'b0);
        check("long_err_pulse",  64'(frame_err), 64'd0);
        send_beat(8'h0B, 1'b1);
        check("long_no_err_end", 64'(frame_err), 64'd0);
        check("long_no_start",   64'(start),     64'd0);
        check("long_vector",     input_vector,   64'h0050_0080_0070_0060);
        send_beat(8'h0C, 1'b0);
        send_beat(8'h0D, 1'b0);
        send_beat(8'h0E, 1'b0);
        send_beat(8'h0F, 1'b1);
        check("long_next_start",  64'(start),   64'd1);
        check("long_next_vector", input_vector, 64'h00F0_00E0_00D0_00C0);
        finish_frame(4'd5);

        // ---------------- reset in WAIT ----------------
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b0);
        send_beat(8'h40, 1'b1);
        check("rw_start", 64'(start), 64'd1);
        step();
        step();
        check("rw_in_wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rw_vector",    input_vector,   64'h0);
        check("rw_res_valid", 64'(res_valid), 64'd0);
        check("rw_pix_ready", 64'(pix_ready), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rw_rel_ready", 64'(pix_ready), 64'd1);
        check("rw_rel_busy",  64'(busy),      64'd0);
        check("rw_rel_start", 64'(start),     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
